// File: rtl/fsm1_pkg.sv
// =====================================================================
// fsm1_pkg -- shared types and constants for the fsm1 read path
// Rev 1.0
// =====================================================================
`default_nettype none

package fsm1_pkg;

    localparam int SEQ_TIMEOUT_DEF = 15;

    // S_XXX is never entered from a legal state; the default branch parks there.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_ERR   = 3'd3,
        S_XXX   = 3'd7
    } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/fsm1_req_fifo.sv
// =====================================================================
// fsm1_req_fifo -- synchronous request FIFO, extra pointer bit for full/empty
// Rev 1.0
// =====================================================================
`default_nettype none

module fsm1_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wptr;
    logic [c_aw:0]    r_rptr;
    logic             w_push;
    logic             w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (c_aw+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (c_aw+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[c_aw-1:0]] <= wdata;
    end

    assign rdata = r_mem[r_rptr[c_aw-1:0]];
    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]) && (r_wptr[c_aw] != r_rptr[c_aw]);

endmodule

`default_nettype wire

// File: rtl/fsm1_req_seq.sv
// =====================================================================
// fsm1_req_seq -- queues burst requests and paces go/ds transactions to fsm1
// Rev 1.0
// =====================================================================
`default_nettype none

module fsm1_req_seq
    import fsm1_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = SEQ_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [LEN_W-1:0] req_len,
    output logic             req_ready,
    output logic             go,
    input  logic             ds,
    output logic             busy,
    output logic             done_pulse,
    output logic [CNT_W-1:0] done_count,
    output logic             err,
    input  logic             err_clr
);

    localparam int                c_tmr_w    = $clog2(TIMEOUT);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT - 1);

    seq_state_e         r_state;
    seq_state_e         w_state_nxt;
    logic [LEN_W-1:0]   r_remaining;
    logic [LEN_W-1:0]   w_remaining_nxt;
    logic [c_tmr_w-1:0] r_timer;
    logic [c_tmr_w-1:0] w_timer_nxt;
    logic [LEN_W-1:0]   w_fifo_len;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_err_nxt;
    logic               w_done_nxt;
    logic               r_go;
    logic               r_done_pulse;
    logic [CNT_W-1:0]   r_done_count;
    logic               r_err;

    assign w_push    = req_valid & ~w_full;
    assign req_ready = ~w_full;
    assign busy      = (r_state != S_IDLE) | ~w_empty;

    fsm1_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LEN_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (req_len),
        .rdata (w_fifo_len),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_timer_nxt     = r_timer;
        w_err_nxt       = r_err;
        w_done_nxt      = 1'b0;
        w_pop           = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Zero-length entries are popped and dropped without issuing.
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_fifo_len != '0) begin
                        w_remaining_nxt = w_fifo_len;
                        w_state_nxt     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                w_timer_nxt = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (ds) begin
                    if (r_remaining == LEN_W'(1)) begin
                        w_done_nxt      = 1'b1;
                        w_remaining_nxt = '0;
                        w_state_nxt     = S_IDLE;
                    end else begin
                        w_remaining_nxt = r_remaining - LEN_W'(1);
                        w_state_nxt     = S_ISSUE;
                    end
                end else if (r_timer == c_tmr_last) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_ERR;
                end else begin
                    w_timer_nxt = r_timer + c_tmr_w'(1);
                end
            end
            S_ERR: begin
                if (err_clr) begin
                    w_err_nxt       = 1'b0;
                    w_remaining_nxt = '0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_XXX;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_remaining  <= '0;
            r_timer      <= '0;
            r_err        <= 1'b0;
            r_go         <= 1'b0;
            r_done_pulse <= 1'b0;
            r_done_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_remaining  <= w_remaining_nxt;
            r_timer      <= w_timer_nxt;
            r_err        <= w_err_nxt;
            r_go         <= (w_state_nxt == S_ISSUE);
            r_done_pulse <= w_done_nxt;
            if (w_done_nxt) r_done_count <= r_done_count + CNT_W'(1);
        end
    end

    assign go         = r_go;
    assign done_pulse = r_done_pulse;
    assign done_count = r_done_count;
    assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fsm1_req_seq.sv
// =====================================================================
// tb_fsm1_req_seq -- directed and randomized bench with a burst-level reference model
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_fsm1_req_seq;

    localparam int DEPTH   = 4;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 15;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             req_valid = 1'b0;
    logic [LEN_W-1:0] req_len   = '0;
    logic             ds        = 1'b0;
    logic             err_clr   = 1'b0;
    logic             req_ready;
    logic             go;
    logic             busy;
    logic             done_pulse;
    logic [CNT_W-1:0] done_count;
    logic             err;

    int checks   = 0;
    int failures = 0;

    // Reference model: accepted non-zero burst lengths in order, plus burst progress.
    int exp_q[$];
    int dly_q[$];
    int exp_cnt     = 0;
    int cur_len     = 0;
    int cur_gos     = 0;
    bit outstanding = 1'b0;
    bit want_go     = 1'b0;
    bit want_done   = 1'b0;
    int go_total    = 0;
    int done_total  = 0;

    // Controller/ws driver knobs.
    int dly_base = 2;
    int ws_pct   = 0;
    bit hold     = 1'b0;
    bit spur     = 1'b0;

    always #5 clk = ~clk;

    fsm1_req_seq #(
        .DEPTH   (DEPTH),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .go         (go),
        .ds         (ds),
        .busy       (busy),
        .done_pulse (done_pulse),
        .done_count (done_count),
        .err        (err),
        .err_clr    (err_clr)
    );

    task automatic check_b(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int next_dly();
        if (dly_q.size() > 0) return dly_q.pop_front();
        return dly_base + (($urandom_range(0, 99) < ws_pct) ? int'($urandom_range(1, 4)) : 0);
    endfunction

    // fsm1 controller stand-in: ds arrives a (possibly ws-stretched) delay after go.
    initial begin : responder
        int cd;
        cd = 0;
        forever begin
            @(negedge clk);
            ds = 1'b0;
            if (!rst_n) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) ds = 1'b1;
                end
                if (go === 1'b1 && !hold) cd = next_dly();
                if (go === 1'b1 && spur) ds = 1'b1;
            end
        end
    end

    // Burst-level checker: go count per burst, go right after a mid-burst ds,
    // done_pulse right after the final ds, and the wrapping completion count.
    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                exp_q.delete();
                exp_cnt     = 0;
                cur_len     = 0;
                cur_gos     = 0;
                outstanding = 1'b0;
                want_go     = 1'b0;
                want_done   = 1'b0;
            end else if (err === 1'b1) begin
                check_b("go_in_err", go, 1'b0);
                cur_len     = 0;
                cur_gos     = 0;
                outstanding = 1'b0;
                want_go     = 1'b0;
                want_done   = 1'b0;
            end else begin
                if (want_go) check_b("go_after_ds", go, 1'b1);
                if (want_done) begin
                    check_b("done_pulse", done_pulse, 1'b1);
                    check_i("done_count", int'(done_count), exp_cnt);
                end else if (done_pulse !== 1'b0) begin
                    check_b("spurious_done", done_pulse, 1'b0);
                end
                if (done_pulse === 1'b1) done_total++;
                want_go   = 1'b0;
                want_done = 1'b0;
                if (ds === 1'b1 && outstanding) begin
                    outstanding = 1'b0;
                    if (cur_gos >= cur_len) begin
                        want_done = 1'b1;
                        exp_cnt   = (exp_cnt + 1) % (1 << CNT_W);
                        cur_gos   = 0;
                    end else begin
                        want_go = 1'b1;
                    end
                end
                if (go === 1'b1) begin
                    go_total++;
                    check_b("go_overlap", outstanding, 1'b0);
                    if (cur_gos == 0) begin
                        if (exp_q.size() == 0) check_b("go_unexpected", go, 1'b0);
                        else cur_len = exp_q.pop_front();
                    end
                    cur_gos++;
                    outstanding = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic push(input int len, output logic acc);
        req_valid = 1'b1;
        req_len   = LEN_W'(len);
        acc       = req_ready;
        if (acc === 1'b1 && len != 0) exp_q.push_back(len);
        tick();
        req_valid = 1'b0;
        req_len   = LEN_W'($urandom_range(0, 15));
    endtask

    task automatic push_wait(input int len);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (acc !== 1'b1 && n < 200) begin
            push(len, acc);
            n++;
        end
        check_b("push_accept_timeout", acc, 1'b1);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while ((busy !== 1'b0 || outstanding) && n < max_cyc) begin
            tick();
            n++;
        end
        check_b("idle_timeout", n < max_cyc, 1'b1);
        tick();
    endtask

    initial begin : safety_net
        #400000;
        $display("FAIL global_timeout: simulation did not reach its summary");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stimulus
        int   base_go;
        int   base_done;
        int   n;
        int   len;
        int   nz_sum;
        int   nz_cnt;
        logic acc;
        int   t3_len[6]   = '{2, 0, 3, 1, 2, 5};
        logic t3_acc[6]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int   wrap_exp[5] = '{1, 2, 3, 0, 1};

        // Reset values.
        tick();
        check_b("rst_go", go, 1'b0);
        check_b("rst_done_pulse", done_pulse, 1'b0);
        check_i("rst_done_count", int'(done_count), 0);
        check_b("rst_err", err, 1'b0);
        check_b("rst_ready", req_ready, 1'b1);
        check_b("rst_busy", busy, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single transaction: go only in the cycle after acceptance.
        dly_base  = 3;
        base_go   = go_total;
        base_done = done_total;
        push(1, acc);
        check_b("t1_accept", acc, 1'b1);
        check_b("t1_go_e0", go, 1'b0);
        tick();
        check_b("t1_go_e1", go, 1'b1);
        check_b("t1_busy", busy, 1'b1);
        tick();
        check_b("t1_go_e2", go, 1'b0);
        wait_idle(50);
        check_i("t1_gos", go_total - base_go, 1);
        check_i("t1_dones", done_total - base_done, 1);
        check_i("t1_count", int'(done_count), 1);
        check_b("t1_busy_end", busy, 1'b0);

        // Three-transaction burst, second transaction stretched by a wait state.
        dly_q     = '{3, 4, 3};
        base_go   = go_total;
        base_done = done_total;
        push(3, acc);
        wait_idle(100);
        check_i("t2_gos", go_total - base_go, 3);
        check_i("t2_dones", done_total - base_done, 1);
        check_i("t2_count", int'(done_count), 2);

        // Back-pressure: first burst stalls, four more fill the FIFO, sixth is refused.
        dly_q     = '{12};
        dly_base  = 2;
        base_go   = go_total;
        base_done = done_total;
        for (int i = 0; i < 6; i++) begin
            push(t3_len[i], acc);
            check_b($sformatf("t3_acc%0d", i), acc, t3_acc[i]);
        end
        check_b("t3_ready_full", req_ready, 1'b0);
        wait_idle(300);
        check_i("t3_gos", go_total - base_go, 8);
        check_i("t3_dones", done_total - base_done, 4);
        check_i("t3_count", int'(done_count), 2);
        check_b("t3_ready_end", req_ready, 1'b1);

        // Watchdog: ds never arrives; err after TIMEOUT cycles in S_WAIT.
        hold      = 1'b1;
        base_go   = go_total;
        base_done = done_total;
        push(2, acc);
        push(1, acc);
        check_b("t4_go", go, 1'b1);
        repeat (TIMEOUT) tick();
        check_b("t4_err_early", err, 1'b0);
        tick();
        check_b("t4_err_set", err, 1'b1);
        repeat (5) tick();
        check_b("t4_err_sticky", err, 1'b1);
        check_b("t4_busy", busy, 1'b1);
        check_i("t4_no_more_go", go_total - base_go, 1);
        hold    = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_b("t4_err_clr", err, 1'b0);
        wait_idle(100);
        check_i("t4_gos", go_total - base_go, 2);
        check_i("t4_dones", done_total - base_done, 1);
        check_i("t4_count", int'(done_count), 3);

        // Reset in the middle of a len=4 burst with another burst queued.
        dly_q   = '{2, 6};
        base_go = go_total;
        push(4, acc);
        push(2, acc);
        n = 0;
        while (go_total - base_go < 2 && n < 50) begin
            tick();
            n++;
        end
        check_b("t5_go_wait", n < 50, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        check_b("t5_go", go, 1'b0);
        check_b("t5_done_pulse", done_pulse, 1'b0);
        check_i("t5_count", int'(done_count), 0);
        check_b("t5_err", err, 1'b0);
        check_b("t5_busy", busy, 1'b0);
        check_b("t5_ready", req_ready, 1'b1);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        push(1, acc);
        wait_idle(50);
        check_i("t5_count_after", int'(done_count), 1);

        // Completion counter wrap with a 2-bit counter.
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            push(1, acc);
            wait_idle(50);
            check_i($sformatf("t6_wrap%0d", i), int'(done_count), wrap_exp[i]);
        end

        // Randomized bursts, ws stretching, spurious ds and stray err_clr.
        ws_pct    = 30;
        base_go   = go_total;
        base_done = done_total;
        nz_sum    = 0;
        nz_cnt    = 0;
        for (int b = 0; b < 30; b++) begin
            len      = int'($urandom_range(0, 5));
            dly_base = int'($urandom_range(1, 3));
            spur     = ($urandom_range(0, 3) == 0);
            if (len != 0) begin
                nz_sum += len;
                nz_cnt++;
            end
            push_wait(len);
            repeat ($urandom_range(0, 3)) begin
                err_clr = ($urandom_range(0, 2) == 0);
                tick();
            end
            err_clr = 1'b0;
        end
        wait_idle(3000);
        check_i("t7_gos", go_total - base_go, nz_sum);
        check_i("t7_dones", done_total - base_done, nz_cnt);
        check_i("t7_queue_drained", exp_q.size(), 0);
        check_b("t7_err", err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
